uart_tx_8bit: RTL and testbench

8-bit UART transmitter serialising one character at a time onto a single line `stx`, paced by the shared 16x baud-rate clock enable. It is the transmit half of the UART core, paired with the existing 8-bit receiver, and supports the same frame formats: 5–8 data bits, optional even/odd parity, 1, 1.5 or 2 stop bits. It also supports break generation. Characters arrive from the transmit holding register/FIFO through a valid/take handshake.

---
 rtl/uart_tx_8bit.sv | 196 +++++++++++++++++++
 tb/tb_uart_tx_8bit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_8bit.sv
// 8-bit UART transmitter: 5..8 data bits, optional even/odd parity, 1 / 1.5 / 2 stop bits,
// break generation. Bit timing is 16 ticks of the shared 16x baud clock enable.
module uart_tx_8bit (
    input  logic       clk,
    input  logic       rst,
    input  logic       brc_x16,
    input  logic [7:0] d,
    input  logic       d_valid,
    output logic       d_take,
    input  logic [3:0] num_bits,
    input  logic       stop_bits,
    input  logic       parity_en,
    input  logic       parity_ev,
    input  logic       break_cb,
    output logic       stx,
    output logic       busy,
    output logic       tsr_empty
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StStop   = 3'd4;

    logic [2:0] state_q, state_d;
    logic [3:0] tick_q, tick_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic       line_q, line_d;
    logic       stx_q;
    // Second phase of a long (1.5 or 2 bit) stop period.
    logic       stop_ext_q, stop_ext_d;

    // Latched frame format.
    logic [2:0] nb_last_q, nb_last_d;
    logic       stop_long_q, stop_long_d;
    logic       stop_half_q, stop_half_d;
    logic       par_en_q, par_en_d;
    logic       par_ev_q, par_ev_d;

    logic [2:0] nb_last_in;
    logic       stop_last;

    // Clamp the requested character length to 5..8 and store it as index of the last bit.
    always_comb begin
        if (num_bits < 4'd5) begin
            nb_last_in = 3'd4;
        end else if (num_bits > 4'd8) begin
            nb_last_in = 3'd7;
        end else begin
            nb_last_in = 3'(num_bits - 4'd1);
        end
    end

    // Final tick of the stop period and the capture handshake.
    always_comb begin
        if (!stop_ext_q) begin
            stop_last = (tick_q == 4'd15) && !stop_long_q;
        end else begin
            stop_last = stop_half_q ? (tick_q == 4'd7) : (tick_q == 4'd15);
        end
        d_take = ((state_q == StIdle) || ((state_q == StStop) && stop_last)) &&
                 brc_x16 && d_valid && !rst;
    end

    // Next-state logic: advances only on a baud tick; capture overrides the end of STOP.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        line_d      = line_q;
        stop_ext_d  = stop_ext_q;
        nb_last_d   = nb_last_q;
        stop_long_d = stop_long_q;
        stop_half_d = stop_half_q;
        par_en_d    = par_en_q;
        par_ev_d    = par_ev_q;

        if (brc_x16) begin
            case (state_q)
                StStart: begin
                    if (tick_q == 4'd15) begin
                        state_d   = StData;
                        tick_d    = 4'd0;
                        bit_cnt_d = 3'd0;
                        line_d    = shift_q[0];
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                StData: begin
                    if (tick_q == 4'd15) begin
                        tick_d  = 4'd0;
                        par_d   = par_q ^ shift_q[0];
                        shift_d = shift_q >> 1;
                        if (bit_cnt_q == nb_last_q) begin
                            if (par_en_q) begin
                                state_d = StParity;
                                line_d  = par_ev_q ? par_d : ~par_d;
                            end else begin
                                state_d    = StStop;
                                stop_ext_d = 1'b0;
                                line_d     = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            line_d    = shift_q[1];
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                StParity: begin
                    if (tick_q == 4'd15) begin
                        state_d    = StStop;
                        tick_d     = 4'd0;
                        stop_ext_d = 1'b0;
                        line_d     = 1'b1;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                StStop: begin
                    if (stop_last) begin
                        state_d    = StIdle;
                        tick_d     = 4'd0;
                        stop_ext_d = 1'b0;
                    end else if (tick_q == 4'd15) begin
                        stop_ext_d = 1'b1;
                        tick_d     = 4'd0;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end

        if (d_take) begin
            state_d     = StStart;
            tick_d      = 4'd0;
            bit_cnt_d   = 3'd0;
            shift_d     = d;
            par_d       = 1'b0;
            line_d      = 1'b0;
            stop_ext_d  = 1'b0;
            nb_last_d   = nb_last_in;
            stop_long_d = stop_bits;
            stop_half_d = stop_bits && (nb_last_in == 3'd4);
            par_en_d    = parity_en;
            par_ev_d    = parity_ev;
        end
    end

    // State registers; break gates the line every clock, independent of baud ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            tick_q      <= 4'd0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            par_q       <= 1'b0;
            line_q      <= 1'b1;
            stx_q       <= 1'b1;
            stop_ext_q  <= 1'b0;
            nb_last_q   <= 3'd7;
            stop_long_q <= 1'b0;
            stop_half_q <= 1'b0;
            par_en_q    <= 1'b0;
            par_ev_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            line_q      <= line_d;
            stx_q       <= line_d & ~break_cb;
            stop_ext_q  <= stop_ext_d;
            nb_last_q   <= nb_last_d;
            stop_long_q <= stop_long_d;
            stop_half_q <= stop_half_d;
            par_en_q    <= par_en_d;
            par_ev_q    <= par_ev_d;
        end
    end

    assign stx       = stx_q;
    assign busy      = (state_q != StIdle);
    assign tsr_empty = (state_q == StIdle);

endmodule

// File: tb/tb_uart_tx_8bit.sv
// Self-checking bench for uart_tx_8bit: per-tick line waveform compared against a frame
// model built from the frame-format rules, with randomized tick spacing and formats.
module tb_uart_tx_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       brc_x16;
    logic [7:0] d;
    logic       d_valid;
    logic       d_take;
    logic [3:0] num_bits;
    logic       stop_bits;
    logic       parity_en;
    logic       parity_ev;
    logic       break_cb;
    logic       stx;
    logic       busy;
    logic       tsr_empty;

    int n_checks = 0;
    int n_errors = 0;
    bit exp_q[$];

    uart_tx_8bit dut (
        .clk       (clk),
        .rst       (rst),
        .brc_x16   (brc_x16),
        .d         (d),
        .d_valid   (d_valid),
        .d_take    (d_take),
        .num_bits  (num_bits),
        .stop_bits (stop_bits),
        .parity_en (parity_en),
        .parity_ev (parity_ev),
        .break_cb  (break_cb),
        .stx       (stx),
        .busy      (busy),
        .tsr_empty (tsr_empty)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Line value expected after each tick of a frame, tick 0 being the capture tick.
    task automatic build_exp(input logic [7:0] data, input int nb_raw, input bit sb,
                             input bit pen, input bit pev);
        int n;
        bit p;
        exp_q.delete();
        n = (nb_raw < 5) ? 5 : ((nb_raw > 8) ? 8 : nb_raw);
        p = 1'b0;
        repeat (16) exp_q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            repeat (16) exp_q.push_back(data[i]);
            p ^= data[i];
        end
        if (pen) repeat (16) exp_q.push_back(pev ? p : !p);
        repeat (!sb ? 16 : ((n == 5) ? 24 : 32)) exp_q.push_back(1'b1);
    endtask

    // One baud tick followed by 0..2 idle clocks; outputs sampled 1 time unit after the edge.
    task automatic tick(input logic dv, input logic brk, output logic take, output logic sx,
                        output logic bz);
        @(negedge clk);
        d_valid  = dv;
        break_cb = brk;
        brc_x16  = 1'b1;
        #1 take = d_take;
        @(posedge clk);
        #1;
        sx = stx;
        bz = busy;
        brc_x16 = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input string name, input logic [7:0] data, input logic [3:0] nb,
                             input logic sb, input logic pen, input logic pev,
                             input bit chained_in, input bit chain_out,
                             input logic [7:0] next_data, input int brk_lo, input int brk_hi);
        logic tk, sx, bz;
        int len;
        bit brk;
        int bad;
        build_exp(data, int'(nb), sb, pen, pev);
        len = exp_q.size();
        if (!chained_in) begin
            tick(1'b0, 1'b0, tk, sx, bz);
            check({name, " idle_take"}, tk, 1'b0);
            check({name, " idle_stx"}, sx, 1'b1);
            d = data; num_bits = nb; stop_bits = sb; parity_en = pen; parity_ev = pev;
            tick(1'b1, 1'b0, tk, sx, bz);
            check({name, " take"}, tk, 1'b1);
            check({name, " busy"}, bz, 1'b1);
            check({name, " tsr_empty"}, tsr_empty, 1'b0);
        end
        check({name, " start"}, stx, exp_q[0]);
        bad = 0;
        for (int k = 1; k < len; k++) begin
            brk = (k >= brk_lo) && (k < brk_hi);
            d         = 8'($urandom);
            num_bits  = 4'($urandom);
            stop_bits = 1'($urandom);
            parity_en = 1'($urandom);
            parity_ev = 1'($urandom);
            tick(chain_out ? 1'b1 : 1'($urandom), brk, tk, sx, bz);
            if (tk !== 1'b0 || sx !== (exp_q[k] & ~brk) || bz !== 1'b1) begin
                bad++;
                check($sformatf("%s tick%0d take", name, k), tk, 1'b0);
                check($sformatf("%s tick%0d stx", name, k), sx, exp_q[k] & ~brk);
                check($sformatf("%s tick%0d busy", name, k), bz, 1'b1);
            end
            if (bad > 4) break;
        end
        d = next_data; num_bits = nb; stop_bits = sb; parity_en = pen; parity_ev = pev;
        tick(chain_out, 1'b0, tk, sx, bz);
        check({name, " end_take"}, tk, chain_out);
        check({name, " end_stx"}, sx, !chain_out);
        check({name, " end_busy"}, bz, chain_out);
        check({name, " end_tsr_empty"}, tsr_empty, !chain_out);
    endtask

    initial begin
        logic tk, sx, bz;
        rst = 1'b1; brc_x16 = 1'b1; d_valid = 1'b1; d = 8'h00; num_bits = 4'd8;
        stop_bits = 1'b0; parity_en = 1'b0; parity_ev = 1'b0; break_cb = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset d_take", d_take, 1'b0);
        check("reset stx", stx, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset tsr_empty", tsr_empty, 1'b1);
        rst = 1'b0; brc_x16 = 1'b0; d_valid = 1'b0;
        @(posedge clk);
        #1;

        run_frame("8N1_55", 8'h55, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
        run_frame("7E1_41", 8'h41, 4'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 0, 0);
        run_frame("5O15_1F", 8'h1F, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
        run_frame("b2b_A5", 8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 0, 0);
        run_frame("b2b_3C", 8'h3C, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 0);
        run_frame("break", 8'h96, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 40, 90);

        // Reset in the middle of data bit 3.
        d = 8'hC6; num_bits = 4'd8; stop_bits = 1'b0; parity_en = 1'b0; parity_ev = 1'b0;
        tick(1'b1, 1'b0, tk, sx, bz);
        check("rst_mid take", tk, 1'b1);
        build_exp(8'hC6, 8, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 70; k++) begin
            tick(1'b0, 1'b0, tk, sx, bz);
            if (k == 70) check("rst_mid bit3", sx, exp_q[k]);
        end
        @(negedge clk);
        rst = 1'b1; brc_x16 = 1'b1; d_valid = 1'b1;
        #1 check("rst_mid d_take", d_take, 1'b0);
        @(posedge clk);
        #1;
        check("rst_mid stx", stx, 1'b1);
        check("rst_mid busy", busy, 1'b0);
        check("rst_mid tsr_empty", tsr_empty, 1'b1);
        @(negedge clk);
        rst = 1'b0; brc_x16 = 1'b0; d_valid = 1'b0;
        @(posedge clk);
        #1;
        run_frame("post_rst", 8'h3A, 4'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 0, 0);

        for (int i = 0; i < 8; i++) begin
            run_frame($sformatf("rand%0d", i), 8'($urandom), 4'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom), 1'b0, 1'b0, 8'h00, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
